microop_sequencer: RTL and testbench

- Control-logic stage that drives the 12-bit microcode ROM address.
- Holds the opcode register, the micro-op counter and the condition latch, and applies the ROM's 32-bit control word back into those registers.
- Decodes the ROM's reg_sel field into a 5-bit register-file index from the opword or ctrl_data.
- Sits between the opword register/bus and the microcode ROM; ROM output is combinational from ADDR.

---
 rtl/microop_sequencer.sv | 154 +++++++++++++++
 tb/tb_microop_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/microop_sequencer.sv
// microop_sequencer
//   Drives the 12-bit microcode ROM address {cond, opcode, count} from three
//   registers: the opcode register, the micro-op counter and the condition
//   latch. Each cycle the ROM control word fed back on UCODE updates them.
//   UCODE[7:6] also selects the register-file index on REG_IDX.
//
//   Optional feature (macro SEQ_HALT_EN): when HALT=1 at an edge, all state
//   holds. Reset still wins over HALT. Without the macro, HALT is ignored.
//
// Ports
//   CLK, N_RST    clock, synchronous active-low reset
//   UCODE[31:0]   ROM control word
//                   [5:0]   ctrl_data
//                   [7:6]   reg_sel
//                   [14:12] in_plane
//                   [15]    misc_plane
//                   [23]    opcode_sel
//                   [25:24] cond_var_sel
//   OPWORD[31:0]  current opword
//                   [31:26] opcode
//                   [25:21] r0
//                   [20:16] r1
//                   [15:11] r2
//   BUS[31:0]     main data bus; BUS[5:0] is an alternate opcode source
//   MLU_ZERO, MLU_CARRY, MLU_NEGATIVE, INTERRUPT
//                 condition sources
//   HALT          freeze request
//   ADDR          {cond, opcode, count} to the microcode ROM
//   REG_IDX       decoded register-file index
//   FAULT         sticky counter-overflow flag
module microop_sequencer #(
  parameter int unsigned OPCODE_W     = 6,
  parameter int unsigned COUNT_W      = 5,
  parameter int unsigned RESET_OPCODE = 0
) (
  input  logic                          CLK,
  input  logic                          N_RST,
  input  logic [31:0]                   UCODE,
  input  logic [31:0]                   OPWORD,
  input  logic [31:0]                   BUS,
  input  logic                          MLU_ZERO,
  input  logic                          MLU_CARRY,
  input  logic                          MLU_NEGATIVE,
  input  logic                          INTERRUPT,
  input  logic                          HALT,
  output logic [OPCODE_W+COUNT_W:0]     ADDR,
  output logic [4:0]                    REG_IDX,
  output logic                          FAULT
);

  localparam logic [2:0] IN_OPCODE = 3'd6;

  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [COUNT_W-1:0]  count_q,  count_d;
  logic                cond_q,   cond_d;
  logic                fault_q,  fault_d;

  logic [5:0] ctrl_data;
  logic [1:0] reg_sel;
  logic [2:0] in_plane;
  logic       misc_plane;
  logic       opcode_sel;
  logic [1:0] cond_var_sel;
  logic       overflow;
  logic       flag_sel;

  assign ctrl_data    = UCODE[5:0];
  assign reg_sel      = UCODE[7:6];
  assign in_plane     = UCODE[14:12];
  assign misc_plane   = UCODE[15];
  assign opcode_sel   = UCODE[23];
  assign cond_var_sel = UCODE[25:24];

  // Counter is about to wrap without a misc_plane restart.
  assign overflow = (count_q == {COUNT_W{1'b1}}) && !misc_plane;

  always_comb begin
    flag_sel = MLU_ZERO;
    case (cond_var_sel)
      2'd0: flag_sel = MLU_ZERO;
      2'd1: flag_sel = MLU_CARRY;
      2'd2: flag_sel = MLU_NEGATIVE;
      2'd3: flag_sel = INTERRUPT;
      default: flag_sel = MLU_ZERO;
    endcase
  end

  always_comb begin
    opcode_d = opcode_q;
    count_d  = count_q + 1'b1;
    cond_d   = flag_sel;
    fault_d  = fault_q;

    if (misc_plane) count_d = '0;

    if (in_plane == IN_OPCODE)
      opcode_d = opcode_sel ? OPCODE_W'(BUS[5:0]) : OPCODE_W'(OPWORD[31:26]);

    // Overflow beats an opcode load in the same cycle.
    if (overflow) begin
      count_d  = '0;
      opcode_d = OPCODE_W'(RESET_OPCODE);
      fault_d  = 1'b1;
    end

`ifdef SEQ_HALT_EN
    if (HALT) begin
      opcode_d = opcode_q;
      count_d  = count_q;
      cond_d   = cond_q;
      fault_d  = fault_q;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (!N_RST) begin
      opcode_q <= OPCODE_W'(RESET_OPCODE);
      count_q  <= '0;
      cond_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      opcode_q <= opcode_d;
      count_q  <= count_d;
      cond_q   <= cond_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    REG_IDX = ctrl_data[4:0];
    case (reg_sel)
      2'd0: REG_IDX = OPWORD[25:21];
      2'd1: REG_IDX = OPWORD[20:16];
      2'd2: REG_IDX = OPWORD[15:11];
      2'd3: REG_IDX = ctrl_data[4:0];
      default: REG_IDX = ctrl_data[4:0];
    endcase
  end

  assign ADDR  = {cond_q, opcode_q, count_q};
  assign FAULT = fault_q;

  // Control-word and input bits that the sequencer does not consume.
  logic unused_bits;
`ifdef SEQ_HALT_EN
  assign unused_bits = ^{ctrl_data[5], UCODE[11:8], UCODE[22:16], UCODE[31:26],
                         OPWORD[10:0], BUS[31:6]};
`else
  assign unused_bits = ^{ctrl_data[5], UCODE[11:8], UCODE[22:16], UCODE[31:26],
                         OPWORD[10:0], BUS[31:6], HALT};
`endif

endmodule

// File: tb/tb_microop_sequencer.sv
module tb_microop_sequencer;

  logic        CLK = 1'b0;
  logic        N_RST;
  logic [31:0] UCODE, OPWORD, BUS;
  logic        MLU_ZERO, MLU_CARRY, MLU_NEGATIVE, INTERRUPT, HALT;
  logic [11:0] ADDR;
  logic [4:0]  REG_IDX;
  logic        FAULT;

  always #5 CLK = ~CLK;

  microop_sequencer dut (
    .CLK(CLK), .N_RST(N_RST), .UCODE(UCODE), .OPWORD(OPWORD), .BUS(BUS),
    .MLU_ZERO(MLU_ZERO), .MLU_CARRY(MLU_CARRY), .MLU_NEGATIVE(MLU_NEGATIVE),
    .INTERRUPT(INTERRUPT), .HALT(HALT), .ADDR(ADDR), .REG_IDX(REG_IDX),
    .FAULT(FAULT)
  );

  typedef struct { int addr; int fault; } exp_t;
  exp_t q_st[$];
  int   q_reg[$];

  int n_chk = 0, n_pass = 0;

  // Reference state as plain integers.
  int m_op = 0, m_cnt = 0, m_cond = 0, m_fault = 0;

  function automatic logic [31:0] uc(input int misc, input int inpl, input int osel,
                                     input int csel, input int rsel, input int cdata);
    uc = 32'(misc) << 15 | 32'(inpl) << 12 | 32'(osel) << 23 |
         32'(csel) << 24 | 32'(rsel) << 6 | 32'(cdata);
  endfunction

  // Issue one cycle of stimulus; flags = {int, neg, carry, zero}.
  task automatic step(input logic [31:0] u, input logic [31:0] ow, input logic [31:0] b,
                      input logic [3:0] fl, input logic rst_n, input logic hlt);
    int misc, inpl, osel, csel, rsel, nxt_op, nxt_cnt;
    exp_t e;
    @(posedge CLK); #3;
    UCODE = u; OPWORD = ow; BUS = b; N_RST = rst_n; HALT = hlt;
    MLU_ZERO = fl[0]; MLU_CARRY = fl[1]; MLU_NEGATIVE = fl[2]; INTERRUPT = fl[3];

    misc = int'(u[15]); inpl = int'(u[14:12]); osel = int'(u[23]);
    csel = int'(u[25:24]); rsel = int'(u[7:6]);

    case (rsel)
      0: q_reg.push_back((ow >> 21) % 32);
      1: q_reg.push_back((ow >> 16) % 32);
      2: q_reg.push_back((ow >> 11) % 32);
      default: q_reg.push_back(u % 32);
    endcase

    if (!rst_n) begin
      m_op = 0; m_cnt = 0; m_cond = 0; m_fault = 0;
    end else begin
      bit frozen = 1'b0;
`ifdef SEQ_HALT_EN
      frozen = hlt;
`endif
      if (!frozen) begin
        if (m_cnt == 31 && misc == 0) begin
          nxt_cnt = 0; nxt_op = 0; m_fault = 1;
        end else begin
          nxt_cnt = misc ? 0 : m_cnt + 1;
          nxt_op  = m_op;
          if (inpl == 6) nxt_op = osel ? int'(b % 64) : int'((ow >> 26) % 64);
        end
        m_cnt = nxt_cnt; m_op = nxt_op; m_cond = int'(fl[csel]);
      end
    end
    e.addr = m_cond * 2048 + m_op * 32 + m_cnt;
    e.fault = m_fault;
    q_st.push_back(e);
  endtask

  // Monitors: state outputs just after the edge, REG_IDX mid-cycle.
  always begin
    exp_t e;
    @(posedge CLK); #1;
    if (q_st.size() > 0) begin
      e = q_st.pop_front();
      n_chk++;
      if (int'(ADDR) == e.addr) n_pass++;
      else $display("FAIL addr t=%0t got=%03h exp=%03h", $time, ADDR, e.addr);
      n_chk++;
      if (int'(FAULT) == e.fault) n_pass++;
      else $display("FAIL fault t=%0t got=%0d exp=%0d", $time, FAULT, e.fault);
    end
  end

  always begin
    int r;
    @(negedge CLK);
    if (q_reg.size() > 0) begin
      r = q_reg.pop_front();
      n_chk++;
      if (int'(REG_IDX) == r) n_pass++;
      else $display("FAIL reg_idx t=%0t got=%0d exp=%0d", $time, REG_IDX, r);
    end
  end

  initial begin
    logic [31:0] u0;
    N_RST = 1'b0; UCODE = '0; OPWORD = '0; BUS = '0; HALT = 1'b0;
    MLU_ZERO = 0; MLU_CARRY = 0; MLU_NEGATIVE = 0; INTERRUPT = 0;
    u0 = uc(0, 0, 0, 0, 0, 0);

    // Reset, then the reset microprogram: 0x000 -> 0x001 -> 0x020.
    step(u0, 0, 0, 4'h0, 0, 0);
    step(u0, 0, 0, 4'h0, 0, 0);
    step(u0, 0, 0, 4'h0, 1, 0);
    step(uc(1, 6, 1, 0, 0, 0), 0, 32'd1, 4'h0, 1, 0);

    // Fetch/dispatch: 0x021..0x024 then 0x100.
    repeat (4) step(u0, 0, 0, 4'h0, 1, 0);
    step(uc(1, 6, 0, 0, 0, 0), 32'd8 << 26, 0, 4'h0, 1, 0);

    // Branch conditions.
    step(u0, 0, 0, 4'h0, 1, 0);
    step(u0, 0, 0, 4'h0, 1, 0);
    step(uc(0, 0, 0, 0, 0, 0), 0, 0, 4'h1, 1, 0);   // zero=1 -> 0x903
    step(uc(0, 0, 0, 0, 0, 0), 0, 0, 4'h0, 1, 0);   // zero=0 -> bit 11 clear
    step(uc(0, 0, 0, 3, 0, 0), 0, 0, 4'h8, 1, 0);   // interrupt -> bit 11
    step(uc(0, 0, 0, 1, 0, 0), 0, 0, 4'h2, 1, 0);   // carry
    step(uc(0, 0, 0, 2, 0, 0), 0, 0, 4'h4, 1, 0);   // negative

    // Register decode.
    for (int i = 0; i < 4; i++)
      step(uc(1, 0, 0, 0, i, 31), 32'h0862_1800, 0, 4'h0, 1, 0);

    // Overflow with opcode 5, load attempted on the overflow edge.
    step(u0, 0, 0, 4'h0, 0, 0);
    step(uc(1, 6, 1, 0, 0, 0), 0, 32'd5, 4'h0, 1, 0);
    repeat (31) step(u0, 0, 0, 4'h0, 1, 0);
    step(uc(0, 6, 1, 0, 0, 0), 0, 32'd7, 4'h0, 1, 0);
    repeat (3) step(u0, 0, 0, 4'h0, 1, 0);
    step(u0, 0, 0, 4'h0, 0, 0);

    // Halt around 0x062; reset during halt.
    step(uc(1, 6, 1, 0, 0, 0), 0, 32'd3, 4'h0, 1, 0);
    step(u0, 0, 0, 4'h0, 1, 0);
    step(u0, 0, 0, 4'h0, 1, 0);
    repeat (3) step(u0, 0, 0, 4'h0, 1, 1);
    step(u0, 0, 0, 4'h0, 1, 0);
    step(u0, 0, 0, 4'h0, 0, 1);
    step(u0, 0, 0, 4'h0, 1, 0);

    // Randomized traffic; misc_plane sparse so overflow happens.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] u, ow, b;
      logic rn, h;
      u  = $urandom;
      u[15] = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) u[14:12] = 3'd6;
      ow = $urandom; b = $urandom;
      rn = ($urandom_range(0, 199) != 0);
      h  = ($urandom_range(0, 7) == 0);
      step(u, ow, b, 4'($urandom), rn, h);
    end

    begin
      int guard = 0;
      while ((q_st.size() > 0 || q_reg.size() > 0) && guard < 10) begin
        @(posedge CLK); guard++;
      end
      #2;
      if (q_st.size() > 0 || q_reg.size() > 0) begin
        n_chk++;
        $display("FAIL drain got=%0d pending exp=0", q_st.size() + q_reg.size());
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
